// File: rtl/uart_apb_initiator_pkg.sv
// uart_apb_initiator_pkg: UART slave register map, status bit positions and FSM encodings.
// No ports; imported by apb_xfer_engine and uart_apb_initiator.
package uart_apb_initiator_pkg;

    localparam logic [4:0] ADDR_TXDATA = 5'h00;
    localparam logic [4:0] ADDR_RXDATA = 5'h04;
    localparam logic [4:0] ADDR_CTRL1  = 5'h08;
    localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;
    localparam logic [4:0] ADDR_CTRL3  = 5'h14;

    localparam int ST_TXRDY    = 0;
    localparam int ST_RXRDY    = 1;
    localparam int ST_PARITY   = 2;
    localparam int ST_OVERFLOW = 3;
    localparam int ST_FRAMING  = 4;

    typedef enum logic [2:0] {
        S_CFG1,
        S_CFG2,
        S_POLL,
        S_RDRX,
        S_WRTX,
        S_GAP
    } state_e;

    typedef enum logic [1:0] {
        X_IDLE,
        X_SETUP,
        X_ACCESS
    } xfer_e;

endpackage

// File: rtl/uart_apb_initiator_apb_xfer_engine.sv
// apb_xfer_engine: runs one APB3 SETUP/ACCESS transfer per request.
// Ports: clk_i/rst_i clock and sync active-high reset; req_i/addr_i/write_i/wdata_i transfer
// request (sampled only while idle); done_o one-cycle completion strobe with rdata_o/slverr_o;
// paddr_o/psel_o/penable_o/pwrite_o/pwdata_o and prdata_i/pready_i/pslverr_i the APB bus.
module apb_xfer_engine
    import uart_apb_initiator_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_i,
    input  logic [4:0] addr_i,
    input  logic       write_i,
    input  logic [7:0] wdata_i,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic       slverr_o,
    output logic [4:0] paddr_o,
    output logic       psel_o,
    output logic       penable_o,
    output logic       pwrite_o,
    output logic [7:0] pwdata_o,
    input  logic [7:0] prdata_i,
    input  logic       pready_i,
    input  logic       pslverr_i
);

    xfer_e      state_q, state_d;
    logic [4:0] paddr_q, paddr_d;
    logic       pwrite_q, pwrite_d;
    logic [7:0] pwdata_q, pwdata_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= X_IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
        end
    end

    // Address/data are captured only when leaving idle, so they stay stable across SETUP+ACCESS
    // and a completed transfer always leaves one idle (PSEL=0) cycle before the next SETUP.
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        case (state_q)
            X_IDLE: if (req_i) begin
                state_d  = X_SETUP;
                paddr_d  = addr_i;
                pwrite_d = write_i;
                pwdata_d = wdata_i;
            end
            X_SETUP:  state_d = X_ACCESS;
            X_ACCESS: state_d = pready_i ? X_IDLE : X_ACCESS;
            default:  state_d = X_IDLE;
        endcase
    end

    assign psel_o    = state_q != X_IDLE;
    assign penable_o = state_q == X_ACCESS;
    assign paddr_o   = paddr_q;
    assign pwrite_o  = pwrite_q;
    assign pwdata_o  = pwdata_q;
    assign done_o    = penable_o && pready_i;
    assign rdata_o   = prdata_i;
    assign slverr_o  = done_o && pslverr_i;

endmodule

// File: rtl/uart_apb_initiator.sv
// uart_apb_initiator: APB3 initiator that configures the UART slave, then polls its status and
// moves bytes between the tx/rx streams and the UART data registers.
// Ports: PCLK/PRESET clock and sync active-high reset; PADDR/PSEL/PENABLE/PWRITE/PWDATA/PRDATA/
// PREADY/PSLVERR the APB bus; tx_valid/tx_data/tx_ready TX stream in; rx_valid/rx_data/rx_ready
// RX stream out; err_clr/err_flags sticky {slverr, framing, overflow, parity}; cfg_done config over.
module uart_apb_initiator
    import uart_apb_initiator_pkg::*;
#(
    parameter logic [12:0] BAUD_VALUE = 13'd0,
    parameter bit          BIT8       = 1'b1,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          ODD_N_EVEN = 1'b0,
    parameter int unsigned POLL_GAP   = 4
) (
    input  logic       PCLK,
    input  logic       PRESET,
    output logic [4:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       err_clr,
    output logic [3:0] err_flags,
    output logic       cfg_done
);

    localparam logic [7:0]  CTRL2_VAL = {BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8};
    localparam logic [15:0] GAP_LAST  = 16'(POLL_GAP - 1);

    state_e      state_q, state_d;
    logic [15:0] gap_q, gap_d;
    logic        tx_full_q, tx_full_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic [3:0]  err_q, err_d, err_set;
    logic        cfg_done_q, cfg_done_d;
    logic        req, xwrite, done, slverr;
    logic [4:0]  xaddr;
    logic [7:0]  xwdata, rdata;

    apb_xfer_engine u_xfer (
        .clk_i     (PCLK),
        .rst_i     (PRESET),
        .req_i     (req),
        .addr_i    (xaddr),
        .write_i   (xwrite),
        .wdata_i   (xwdata),
        .done_o    (done),
        .rdata_o   (rdata),
        .slverr_o  (slverr),
        .paddr_o   (PADDR),
        .psel_o    (PSEL),
        .penable_o (PENABLE),
        .pwrite_o  (PWRITE),
        .pwdata_o  (PWDATA),
        .prdata_i  (PRDATA),
        .pready_i  (PREADY),
        .pslverr_i (PSLVERR)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= S_CFG1;
            gap_q      <= '0;
            tx_full_q  <= 1'b0;
            tx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            err_q      <= '0;
            cfg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            tx_full_q  <= tx_full_d;
            tx_byte_q  <= tx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            err_q      <= err_d;
            cfg_done_q <= cfg_done_d;
        end
    end

    // Every state except GAP owns exactly one transfer; the engine ignores req while busy and
    // the state advances on done, so each state issues its transfer once.
    always_comb begin
        req    = state_q != S_GAP;
        xaddr  = state_q == S_CFG1 ? ADDR_CTRL1  :
                 state_q == S_CFG2 ? ADDR_CTRL2  :
                 state_q == S_RDRX ? ADDR_RXDATA :
                 state_q == S_WRTX ? ADDR_TXDATA : ADDR_STATUS;
        xwrite = state_q inside {S_CFG1, S_CFG2, S_WRTX};
        xwdata = state_q == S_CFG1 ? BAUD_VALUE[7:0] :
                 state_q == S_CFG2 ? CTRL2_VAL       : tx_byte_q;
    end

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        tx_full_d  = tx_full_q;
        tx_byte_d  = tx_byte_q;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        cfg_done_d = cfg_done_q;
        err_set    = '0;
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        if (tx_valid && tx_ready) begin
            tx_full_d = 1'b1;
            tx_byte_d = tx_data;
        end
        if (done) begin
            err_set[3] = slverr;
            case (state_q)
                S_CFG1: state_d = S_CFG2;
                S_CFG2: begin
                    state_d    = S_POLL;
                    cfg_done_d = 1'b1;
                end
                S_POLL: begin
                    err_set[2:0] = {rdata[ST_FRAMING], rdata[ST_OVERFLOW], rdata[ST_PARITY]};
                    gap_d        = '0;
                    // RX has priority; a full RX holding reg defers the read (backpressure).
                    state_d = (rdata[ST_RXRDY] && !rx_valid_q) ? S_RDRX :
                              (rdata[ST_TXRDY] && tx_full_q)   ? S_WRTX :
                              (POLL_GAP == 0)                  ? S_POLL : S_GAP;
                end
                S_RDRX: begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = rdata;
                    state_d    = S_POLL;
                end
                S_WRTX: begin
                    tx_full_d = 1'b0;
                    state_d   = S_POLL;
                end
                default: state_d = S_POLL;
            endcase
        end else if (state_q == S_GAP) begin
            gap_d   = gap_q + 16'd1;
            state_d = gap_q == GAP_LAST ? S_POLL : S_GAP;
        end
        // A new error in the same cycle as err_clr survives the clear.
        err_d = (err_clr ? 4'b0000 : err_q) | err_set;
    end

    assign tx_ready  = !tx_full_q && cfg_done_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign err_flags = err_q;
    assign cfg_done  = cfg_done_q;

endmodule

// File: tb/tb_uart_apb_initiator.sv
// tb_uart_apb_initiator: random APB slave plus transaction-level reference model for uart_apb_initiator.
module tb_uart_apb_initiator;

    localparam int GAP = 4;
    localparam int K_CFG1 = 0, K_CFG2 = 1, K_POLL = 2, K_RDRX = 3, K_WRTX = 4;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic [4:0] PADDR;
    logic       PSEL, PENABLE, PWRITE;
    logic [7:0] PWDATA, PRDATA;
    logic       PREADY, PSLVERR;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [3:0] err_flags;
    logic       cfg_done;

    uart_apb_initiator #(
        .BAUD_VALUE (13'h0A5B),
        .BIT8       (1'b1),
        .PARITY_EN  (1'b1),
        .ODD_N_EVEN (1'b0),
        .POLL_GAP   (GAP)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .err_clr   (err_clr),
        .err_flags (err_flags),
        .cfg_done  (cfg_done)
    );

    always #5 PCLK = ~PCLK;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // APB slave: random wait states (first transfer after reset always 3), random status/rx byte/slverr.
    int         acc_cnt = 0, wait_n = 0, xfer_no = 0;
    logic [7:0] status_v = 8'h00, rxb_v = 8'h00;
    logic       slverr_v = 1'b0;

    assign PREADY  = PSEL && PENABLE && (acc_cnt == wait_n);
    assign PRDATA  = PADDR == 5'h10 ? status_v : PADDR == 5'h04 ? rxb_v : 8'h00;
    assign PSLVERR = PREADY && slverr_v;

    always @(posedge PCLK) begin
        if (PRESET) begin
            acc_cnt <= 0;
            xfer_no <= 0;
        end else begin
            if (PSEL && !PENABLE) begin
                wait_n   <= xfer_no == 0 ? 3 : int'($urandom_range(0, 3));
                status_v <= {3'b000, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                             $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
                rxb_v    <= 8'($urandom);
                slverr_v <= $urandom_range(0, 9) == 0;
                xfer_no  <= xfer_no + 1;
            end
            if (PSEL && PENABLE) acc_cnt <= PREADY ? 0 : acc_cnt + 1;
        end
    end

    // Reference model: which transfer comes next, and the stream/flag state, from the behavioural rules.
    int         kind = K_CFG1, need_idle = 1, idle = 0, acc_len = 0, stall = 0;
    logic       pending = 1'b0;
    logic       m_cfg = 1'b0, m_txf = 1'b0, m_rxv = 1'b0;
    logic [7:0] m_txb = 8'h00, m_rxb = 8'h00;
    logic [3:0] m_err = 4'h0;
    logic [4:0] s_addr = 5'h00;
    logic       s_write = 1'b0;
    logic [7:0] s_wdata = 8'h00;

    function automatic logic [4:0] k_addr(input int k);
        return k == K_CFG1 ? 5'h08 : k == K_CFG2 ? 5'h0C : k == K_RDRX ? 5'h04 : k == K_WRTX ? 5'h00 : 5'h10;
    endfunction

    always @(negedge PCLK) begin
        logic       ntxf, nrxv, ncfg, ew;
        logic [7:0] ntxb, nrxb;
        logic [3:0] nerr;
        int         nkind;
        chk("tx_ready", tx_ready, !m_txf && m_cfg);
        chk("rx_valid", rx_valid, m_rxv);
        chk("rx_data", rx_data, m_rxb);
        chk("err_flags", err_flags, m_err);
        chk("cfg_done", cfg_done, m_cfg);
        if (PRESET) begin
            kind = K_CFG1; need_idle = 1; idle = 0; stall = 0; pending = 1'b0;
            m_cfg = 1'b0; m_txf = 1'b0; m_rxv = 1'b0; m_txb = 8'h00; m_rxb = 8'h00; m_err = 4'h0;
        end else begin
            ntxf = m_txf; ntxb = m_txb; nrxv = m_rxv; nrxb = m_rxb; ncfg = m_cfg; nerr = 4'h0; nkind = kind;
            if (m_rxv && rx_ready) nrxv = 1'b0;
            if (tx_valid && !m_txf && m_cfg) begin
                ntxf = 1'b1;
                ntxb = tx_data;
            end
            stall = (PSEL && PENABLE && PREADY) ? 0 : stall + 1;
            if (!PSEL) idle++;
            else if (!PENABLE) begin
                chk("idle_before_setup", idle >= need_idle, 1);
                chk("overlap", pending, 0);
                idle = 0; pending = 1'b1; acc_len = 0;
                s_addr = PADDR; s_write = PWRITE; s_wdata = PWDATA;
            end else begin
                acc_len++;
                chk("paddr_stable", PADDR, s_addr);
                chk("pwrite_stable", PWRITE, s_write);
                chk("pwdata_stable", PWDATA, s_wdata);
                if (PREADY) begin
                    pending = 1'b0;
                    ew = kind == K_CFG1 || kind == K_CFG2 || kind == K_WRTX;
                    chk("paddr", PADDR, k_addr(kind));
                    chk("pwrite", PWRITE, ew);
                    if (ew) chk("pwdata", PWDATA, kind == K_CFG1 ? 8'h5B : kind == K_CFG2 ? 8'h53 : m_txb);
                    if (kind == K_CFG1) chk("cfg1_access_cycles", acc_len, 4);
                    nerr[3] = PSLVERR; need_idle = 1; nkind = K_POLL;
                    if (kind == K_CFG1) nkind = K_CFG2;
                    else if (kind == K_CFG2) ncfg = 1'b1;
                    else if (kind == K_RDRX) begin
                        nrxv = 1'b1;
                        nrxb = PRDATA;
                    end else if (kind == K_WRTX) ntxf = 1'b0;
                    else begin
                        nerr[2:0] = PRDATA[4:2];
                        if (PRDATA[1] && !m_rxv) nkind = K_RDRX;
                        else if (PRDATA[0] && m_txf) nkind = K_WRTX;
                        else need_idle = GAP;
                    end
                end
            end
            m_txf = ntxf; m_txb = ntxb; m_rxv = nrxv; m_rxb = nrxb; m_cfg = ncfg; kind = nkind;
            m_err = (err_clr ? 4'h0 : m_err) | nerr;
        end
    end

    logic dead = 1'b0;

    task automatic run(input int n, input logic hold_rx);
        for (int i = 0; i < n && !dead; i++) begin
            @(posedge PCLK);
            #2;
            tx_valid = 1'($urandom_range(0, 1));
            tx_data  = 8'($urandom);
            rx_ready = hold_rx ? 1'b0 : 1'($urandom_range(0, 1));
            err_clr  = $urandom_range(0, 15) == 0;
            if (stall > 150) begin
                chk("watchdog_stall", stall, 0);
                dead = 1'b1;
            end
        end
    endtask

    initial begin
        logic found;
        repeat (3) @(posedge PCLK);
        #2;
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_err_flags", err_flags, 0);
        chk("rst_cfg_done", cfg_done, 0);
        PRESET = 1'b0;
        run(1500, 1'b0);
        run(200, 1'b1);
        run(1000, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 300 && !found && !dead; i++) begin
            @(posedge PCLK);
            #2;
            found = PSEL && PENABLE && !PREADY;
        end
        chk("mid_access_found", found, 1);
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        chk("mid_rst_psel", PSEL, 0);
        chk("mid_rst_penable", PENABLE, 0);
        chk("mid_rst_cfg_done", cfg_done, 0);
        chk("mid_rst_rx_valid", rx_valid, 0);
        PRESET = 1'b0;
        run(1000, 1'b0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
